// File: rtl/bit8_look_ahead_carry_adder.sv
// 8-bit two-level carry-lookahead adder with registered sum, carry and bitwise AND/OR/XOR results.
// Optional macro LAC_GROUP_PG_EN adds registered slice propagate/generate outputs P_out/G_out.
module bit8_look_ahead_carry_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A_in,
  input  logic [7:0] B_in,
  input  logic       C_in,
  output logic [7:0] S_out,
  output logic       C_out,
  output logic [7:0] AND_out,
  output logic [7:0] OR_out,
  output logic [7:0] XOR_out
`ifdef LAC_GROUP_PG_EN
  ,
  output logic       P_out,
  output logic       G_out
`endif
);

  localparam int GRP = 4;

  // Packed result of one 4-bit lookahead group: {gp, gg, c3, c2, c1}.
  typedef struct packed {
    logic       gp;
    logic       gg;
    logic [3:1] c;
  } grp_res_t;

  // Fully expanded in-group lookahead; carries never ripple through neighbouring bits.
  function automatic grp_res_t lac_group(input logic [GRP-1:0] g,
                                         input logic [GRP-1:0] p,
                                         input logic           c0);
    grp_res_t r;
    r.c[1] = g[0] | (p[0] & c0);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.gp   = p[3] & p[2] & p[1] & p[0];
    return r;
  endfunction

  logic [7:0] g_s;
  logic [7:0] p_s;
  logic [8:0] c_s;
  logic [7:0] sum_s;
  grp_res_t   grp0_s;
  grp_res_t   grp1_s;

  logic [7:0] sum_r;
  logic       cout_r;
  logic [7:0] and_r;
  logic [7:0] or_r;
  logic [7:0] xor_r;

  // Bit-level generate/propagate, both lookahead levels and the sum.
  always_comb begin
    g_s    = A_in & B_in;
    p_s    = A_in ^ B_in;
    c_s    = 9'd0;
    c_s[0] = C_in;
    // Second level resolves c4 and c8 from group terms before the upper group's inner carries.
    grp0_s = lac_group(g_s[3:0], p_s[3:0], c_s[0]);
    c_s[4] = grp0_s.gg | (grp0_s.gp & C_in);
    grp1_s = lac_group(g_s[7:4], p_s[7:4], c_s[4]);
    c_s[8] = grp1_s.gg | (grp1_s.gp & grp0_s.gg) | (grp1_s.gp & grp0_s.gp & C_in);
    c_s[3:1] = grp0_s.c;
    c_s[7:5] = grp1_s.c;
    sum_s  = p_s ^ c_s[7:0];
  end

  // Output registers: all results captured from the same operand sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= 8'd0;
      cout_r <= 1'b0;
      and_r  <= 8'd0;
      or_r   <= 8'd0;
      xor_r  <= 8'd0;
    end else begin
      sum_r  <= sum_s;
      cout_r <= c_s[8];
      and_r  <= g_s;
      or_r   <= A_in | B_in;
      xor_r  <= p_s;
    end
  end

  assign S_out   = sum_r;
  assign C_out   = cout_r;
  assign AND_out = and_r;
  assign OR_out  = or_r;
  assign XOR_out = xor_r;

`ifdef LAC_GROUP_PG_EN
  logic pg_p_s;
  logic pg_g_s;
  logic pg_p_r;
  logic pg_g_r;

  // Slice-level propagate/generate for an upper lookahead level.
  always_comb begin
    pg_p_s = grp1_s.gp & grp0_s.gp;
    pg_g_s = grp1_s.gg | (grp1_s.gp & grp0_s.gg);
  end

  // Slice propagate/generate registers, same latency as the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_p_r <= 1'b0;
      pg_g_r <= 1'b0;
    end else begin
      pg_p_r <= pg_p_s;
      pg_g_r <= pg_g_s;
    end
  end

  assign P_out = pg_p_r;
  assign G_out = pg_g_r;
`endif

endmodule

// File: tb/tb_bit8_look_ahead_carry_adder.sv
// Directed and swept self-checking bench for bit8_look_ahead_carry_adder.
// Covers LAC_GROUP_PG_EN outputs when that macro is defined.
module tb_bit8_look_ahead_carry_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_in = 8'd0;
  logic [7:0] b_in = 8'd0;
  logic       c_in = 1'b0;
  logic [7:0] s_out;
  logic       c_out;
  logic [7:0] and_out;
  logic [7:0] or_out;
  logic [7:0] xor_out;
`ifdef LAC_GROUP_PG_EN
  logic       p_out;
  logic       g_out;
`endif

  int checks = 0;
  int errors = 0;

  bit8_look_ahead_carry_adder dut (
    .clk     (clk),
    .rst     (rst),
    .A_in    (a_in),
    .B_in    (b_in),
    .C_in    (c_in),
    .S_out   (s_out),
    .C_out   (c_out),
    .AND_out (and_out),
    .OR_out  (or_out),
    .XOR_out (xor_out)
`ifdef LAC_GROUP_PG_EN
    ,
    .P_out   (p_out),
    .G_out   (g_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] s, input logic c,
                         input logic [7:0] an, input logic [7:0] orr, input logic [7:0] x);
    chk({tag, "_sum"}, {c_out, s_out}, {c, s});
    chk({tag, "_and"}, {1'b0, and_out}, {1'b0, an});
    chk({tag, "_or"},  {1'b0, or_out},  {1'b0, orr});
    chk({tag, "_xor"}, {1'b0, xor_out}, {1'b0, x});
  endtask

  task automatic chk_pg(input string tag, input logic p, input logic g);
`ifdef LAC_GROUP_PG_EN
    chk({tag, "_pg"}, {7'd0, p_out, g_out}, {7'd0, p, g});
`endif
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_in = a;
    b_in = b;
    c_in = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] ref_sum;
    a_in = 8'h5A; b_in = 8'hC3; c_in = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk_all("rst_async", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_pg("rst_async", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_held", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    apply(8'h94, 8'h35, 1'b1);
    chk_all("v94_35", 8'hCA, 1'b0, 8'h14, 8'hB5, 8'hA1);
    chk_pg("v94_35", 1'b0, 1'b0);

    // Mid-run reset must clear outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk_all("rst_mid", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    chk_pg("rst_mid", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_mid_edge", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    apply(8'hFF, 8'h00, 1'b1);
    chk_all("vFF_00", 8'h00, 1'b1, 8'h00, 8'hFF, 8'hFF);
    chk_pg("vFF_00", 1'b1, 1'b0);

    apply(8'h80, 8'h80, 1'b0);
    chk_all("v80_80", 8'h00, 1'b1, 8'h80, 8'h80, 8'h00);
    chk_pg("v80_80", 1'b0, 1'b1);

    apply(8'hFF, 8'hFF, 1'b1);
    chk_all("vFF_FF", 8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00);
    chk_pg("vFF_FF", 1'b0, 1'b1);

    apply(8'h0F, 8'h01, 1'b0);
    chk_all("v0F_01", 8'h10, 1'b0, 8'h01, 8'h0F, 8'h0E);
    chk_pg("v0F_01", 1'b0, 1'b0);

    // Full A x B sweep; carry-in alternates with operand bits so both values are covered.
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        a = ai[7:0];
        b = bi[7:0];
        c = a[0] ^ b[7] ^ b[0];
        apply(a, b, c);
        ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
        chk_all("sweep", ref_sum[7:0], ref_sum[8], a & b, a | b, a ^ b);
`ifdef LAC_GROUP_PG_EN
        ref_sum = {1'b0, a} + {1'b0, b};
        chk_pg("sweep", (a ^ b) == 8'hFF, ref_sum[8]);
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
